// File: rtl/ot_mem_pkg.sv
// ot_mem_pkg: shared types and constants for the OT accelerator buffer-RAM
// arbiter.
//   state_t      - arbiter state (zero-fill, then normal operation)
//   DEF_*        - default geometry for the buffer RAM and requester count
//   req_idx_w()  - width of a requester index (at least 1 bit)
package ot_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_NUM_REQ    = 4;

  function automatic int req_idx_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  localparam int REQ_IDX_W = req_idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal priority pointer.
//   clk, rst   - clock, asynchronous active-high reset (pointer -> 0)
//   req        - request vector
//   en         - arbitration enable; no grant while low
//   grant      - one-hot grant (zero when nothing granted)
//   grant_idx  - index of the granted requester
//   grant_vld  - a grant was issued this cycle
// The first requester at index >= ptr wins, wrapping around. The pointer
// moves to one past the winner, and only when a grant is issued.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 0;
    jj        = '0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        // Scan ptr, ptr+1, ... modulo NUM_REQ. The first hit sticks.
        j = int'(ptr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        jj = IDX_W'(j);
        if (!grant_vld && req[jj]) begin
          grant_vld = 1'b1;
          grant_idx = jj;
          grant[jj] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one simple dual-port block RAM (one write port,
// one read port) between NUM_REQ requesters.
//   clk, rst        - clock, asynchronous active-high reset
//   req_*           - per-requester valid / write-select / address / wdata
//   req_ready       - request accepted this cycle (combinational)
//   rsp_valid       - one-hot read-response strobe, one cycle after grant
//   rsp_rdata       - shared read data (passthrough of mem_data_out)
//   init_done       - zero-fill finished; stays high until reset
//   mem_*           - direct drive of the RAM ports. mem_data_out is the
//                     registered RAM output, valid the cycle after mem_rd_en.
// After reset the whole RAM is zero-filled, one word per cycle. After that,
// writes and reads are arbitrated independently, each by its own round-robin
// arbiter. A write grant and a read grant can therefore go to two different
// requesters in the same cycle.
module bram_port_arbiter
  import ot_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                init_done,
  output logic                                mem_wr_en,
  output logic [ADDR_WIDTH-1:0]               mem_write_addr,
  output logic [DATA_WIDTH-1:0]               mem_data_in,
  output logic                                mem_rd_en,
  output logic [ADDR_WIDTH-1:0]               mem_read_addr,
  input  logic [DATA_WIDTH-1:0]               mem_data_out
);

  localparam int IDX_W = req_idx_w(NUM_REQ);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fill_addr;
  logic                    run;

  logic [NUM_REQ-1:0]      wr_grant, rd_grant;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic                    wr_vld, rd_vld;

  logic                    rsp_pend;
  logic [IDX_W-1:0]        rsp_id;

  assign run = (state == ST_RUN);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid & req_we),
    .en        (run),
    .grant     (wr_grant),
    .grant_idx (wr_idx),
    .grant_vld (wr_vld)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid & ~req_we),
    .en        (run),
    .grant     (rd_grant),
    .grant_idx (rd_idx),
    .grant_vld (rd_vld)
  );

  // Zero-fill sequencer. init_done is set on the edge that writes the last
  // address, together with the move to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      fill_addr <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          fill_addr <= fill_addr + 1'b1;
          if (&fill_addr) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // The read-grant id is carried one cycle to line up with the RAM's
  // registered output. Reset drops any response still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
    end else begin
      rsp_pend <= rd_vld;
      if (rd_vld) rsp_id <= rd_idx;
    end
  end

  // RAM port drive. The fill write is gated by rst so that the RAM sees no
  // write enable while reset is held.
  always_comb begin
    mem_wr_en      = 1'b0;
    mem_write_addr = '0;
    mem_data_in    = '0;
    mem_rd_en      = 1'b0;
    mem_read_addr  = '0;
    if (!rst && state == ST_INIT) begin
      mem_wr_en      = 1'b1;
      mem_write_addr = fill_addr;
    end else if (wr_vld) begin
      mem_wr_en      = 1'b1;
      mem_write_addr = req_addr[wr_idx];
      mem_data_in    = req_wdata[wr_idx];
    end
    if (rd_vld) begin
      mem_rd_en     = 1'b1;
      mem_read_addr = req_addr[rd_idx];
    end
  end

  // The write and read candidate sets are disjoint (split on req_we), so OR
  // of the two grants stays at most one bit per requester.
  assign req_ready = wr_grant | rd_grant;

  always_comb begin
    rsp_valid = '0;
    if (rsp_pend) rsp_valid[rsp_id] = 1'b1;
  end

  assign rsp_rdata = mem_data_out;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural read-first BRAM.
module tb_bram_port_arbiter;
  import ot_mem_pkg::*;

  localparam int DW = 128;
  localparam int AW = 6;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]         req_valid, req_we, req_ready, rsp_valid;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]         rsp_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]         mem_write_addr, mem_read_addr;
  logic                  init_done, mem_wr_en, mem_rd_en;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .mem_wr_en(mem_wr_en), .mem_write_addr(mem_write_addr),
    .mem_data_in(mem_data_in), .mem_rd_en(mem_rd_en),
    .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out)
  );

  // Simple dual-port RAM, registered read, read-first on collision.
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (mem_rd_en) ram_q <= ram[mem_read_addr];
    if (mem_wr_en) ram[mem_write_addr] <= mem_data_in;
  end
  assign mem_data_out = ram_q;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic wr(input int r, input int a, input logic [DW-1:0] d);
    req_valid[r] = 1'b1;
    req_we[r]    = 1'b1;
    req_addr[r]  = AW'(a);
    req_wdata[r] = d;
  endtask

  task automatic rd(input int r, input int a);
    req_valid[r] = 1'b1;
    req_we[r]    = 1'b0;
    req_addr[r]  = AW'(a);
  endtask

  logic [DW-1:0] a5;

  initial begin
    a5 = {16{8'hA5}};
    for (int i = 0; i < 2**AW; i++) ram[i] = {4{32'hDEADBEEF}} ^ DW'(i);
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_init_done", init_done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_waddr", mem_write_addr, 0);

    // Zero-fill with read requests pending that must not be accepted
    req_valid = 4'hF;
    req_we    = 4'h0;
    rst       = 1'b0;
    for (int c = 0; c < 2**AW; c++) begin
      #1;
      chk("fill_wr_en", mem_wr_en, 1);
      chk("fill_addr", mem_write_addr, c);
      chk("fill_data", mem_data_in, 0);
      chk("fill_ready", req_ready, 0);
      chk("fill_rd_en", mem_rd_en, 0);
      chk("fill_done", init_done, 0);
      if (c == 2**AW - 1) idle();
      tick();
    end
    chk("init_done", init_done, 1);
    chk("run_idle_wr_en", mem_wr_en, 0);
    chk("run_idle_ready", req_ready, 0);

    // Write rotation: all four write continuously
    for (int r = 0; r < NR; r++) wr(r, 20 + r, DW'(100 + r));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rot_ready", req_ready, 1 << (k % 4));
      chk("rot_addr", mem_write_addr, 20 + (k % 4));
      chk("rot_data", mem_data_in, 100 + (k % 4));
      tick();
    end
    // wr_ptr is now 2: requesters 1 and 3 only -> 3 first, then 1
    idle();
    wr(1, 31, DW'(131));
    wr(3, 33, DW'(133));
    #1;
    chk("ptr2_first", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    #1;
    chk("ptr2_second", req_ready, 4'b0010);
    chk("ptr2_addr", mem_write_addr, 31);
    tick();
    idle();

    // Write A5 then read it back through requester 2
    wr(2, 10, a5);
    #1;
    chk("a5_wr_ready", req_ready, 4'b0100);
    tick();
    idle();
    rd(2, 10);
    #1;
    chk("a5_rd_ready", req_ready, 4'b0100);
    chk("a5_rd_en", mem_rd_en, 1);
    chk("a5_rd_addr", mem_read_addr, 10);
    chk("a5_no_rsp_yet", rsp_valid, 0);
    tick();
    idle();
    #1;
    chk("a5_rsp_valid", rsp_valid, 4'b0100);
    chk("a5_rsp_data", rsp_rdata, a5);
    tick();
    chk("a5_rsp_gone", rsp_valid, 0);

    // Same-address read and write: read-first
    wr(0, 5, DW'(7));
    tick();
    idle();
    wr(0, 5, DW'(1));
    rd(1, 5);
    #1;
    chk("coll_ready", req_ready, 4'b0011);
    tick();
    idle();
    #1;
    chk("coll_rsp_valid", rsp_valid, 4'b0010);
    chk("coll_old_data", rsp_rdata, 7);
    rd(1, 5);
    tick();
    idle();
    #1;
    chk("coll_new_data", rsp_rdata, 1);

    // Zero-filled location
    rd(0, 37);
    tick();
    idle();
    #1;
    chk("fill37_valid", rsp_valid, 4'b0001);
    chk("fill37_data", rsp_rdata, 0);

    // Back-to-back reads by requester 3
    for (int k = 0; k < 4; k++) begin
      idle();
      wr(0, k, DW'(256 + k));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      rd(3, k);
      #1;
      chk("b2b_ready", req_ready, 4'b1000);
      if (k > 0) begin
        chk("b2b_valid", rsp_valid, 4'b1000);
        chk("b2b_data", rsp_rdata, 256 + k - 1);
      end
      tick();
    end
    idle();
    #1;
    chk("b2b_last_valid", rsp_valid, 4'b1000);
    chk("b2b_last_data", rsp_rdata, 256 + 3);
    tick();
    chk("b2b_done", rsp_valid, 0);

    // Reset during a read: response dropped, fill restarts from 0
    rd(2, 10);
    #1;
    chk("mid_rd_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rsp_dropped", rsp_valid, 0);
    chk("mid_init_done", init_done, 0);
    chk("mid_wr_en", mem_wr_en, 0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    chk("refill_en", mem_wr_en, 1);
    chk("refill_addr0", mem_write_addr, 0);
    tick();
    chk("refill_addr1", mem_write_addr, 1);
    chk("refill_no_rsp", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
